// File: rtl/param_cfg_pkg.sv
// Shared types, widths, addresses and string helper for the config sequencer.
package param_cfg_pkg;

  typedef enum logic [2:0] {StIdle, StSend, StGap, StCsum, StDone} state_e;

  localparam int unsigned CFG_ADDR_W    = 4;
  localparam int unsigned CFG_DATA_W    = 8;
  localparam logic [CFG_ADDR_W-1:0] CSUM_ADDR = 4'hF;
  localparam int unsigned STR_BASE_ADDR = 2;
  localparam int unsigned MAX_STR_LEN   = 13;

  // String literals are right-aligned, so character k (leftmost = 0) sits at byte len-1-k.
  function automatic logic [CFG_DATA_W-1:0] str_byte(input logic [8*MAX_STR_LEN-1:0] s,
                                                     input int unsigned len,
                                                     input int unsigned k);
    if (k >= len) return '0;
    return CFG_DATA_W'(s >> (8 * (len - 1 - k)));
  endfunction

endpackage

// File: rtl/param_cfg_sequencer_if.sv
// Valid/ready config-write port between the sequencer and the config register file.
interface param_cfg_sequencer_if;
  import param_cfg_pkg::*;

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CFG_ADDR_W-1:0] cfg_addr;
  logic [CFG_DATA_W-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);

endinterface

// File: rtl/param_cfg_gap_timer.sv
// Loadable down-counter timing the idle gap after each accepted config word.
module param_cfg_gap_timer #(
  parameter int unsigned GapCycles = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic tick_i,
  output logic expired_o,
  output logic bypass_o
);

  // Loaded with GapCycles-1 so the gap state is left on the GapCycles-th edge.
  localparam int unsigned LoadVal = (GapCycles > 0) ? GapCycles - 1 : 0;
  localparam int unsigned CntW    = (LoadVal > 0) ? $clog2(LoadVal + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(LoadVal);
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);
  assign bypass_o  = (GapCycles == 0);

endmodule

// File: rtl/param_cfg_sequencer.sv
// Post-reset config sequencer: streams parameter bytes as config writes, then releases O.
// Optional trailing checksum word at CSUM_ADDR when PARAM_CFG_CHECKSUM_EN is defined.
module param_cfg_sequencer
  import param_cfg_pkg::*;
#(
  parameter int                         PARAM_INTEGER       = 10,
  parameter logic [7:0]                 PARAM_INTEGER_SIZED = 8'(65535),
  parameter logic [8*MAX_STR_LEN-1:0]   PARAM_STRING        = (8*MAX_STR_LEN)'("A string."),
  parameter int unsigned                STR_LEN             = 9,
  parameter int unsigned                GAP_CYCLES          = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         I,
  output logic                         O,
  input  logic                         start,
  param_cfg_sequencer_if.master        cfg_if,
  output logic                         done,
  output logic                         busy
);

  if (STR_LEN < 1 || STR_LEN > MAX_STR_LEN) begin : g_bad_str_len
    $error("param_cfg_sequencer: STR_LEN must be in 1..13");
  end

  localparam logic [7:0] IntByte = 8'(PARAM_INTEGER);
  localparam logic [3:0] LastIdx = 4'(STR_BASE_ADDR + STR_LEN - 1);

  // Word address equals table index, so only the data byte needs a lookup.
  function automatic logic [CFG_DATA_W-1:0] word_data(input logic [3:0] idx);
    if (idx == 4'd0) return IntByte;
    if (idx == 4'd1) return PARAM_INTEGER_SIZED;
    return str_byte(PARAM_STRING, STR_LEN, 32'(idx) - STR_BASE_ADDR);
  endfunction

  state_e                state_q;
  logic [3:0]            idx_q;
  logic                  valid_q;
  logic [CFG_ADDR_W-1:0] addr_q;
  logic [CFG_DATA_W-1:0] data_q;
  logic                  done_q;
`ifdef PARAM_CFG_CHECKSUM_EN
  logic [CFG_DATA_W-1:0] csum_q;
`endif

  logic gap_load, gap_tick, gap_expired, gap_bypass;

  assign gap_load = (state_q == StSend) && cfg_if.cfg_ready && (idx_q != LastIdx);
  assign gap_tick = (state_q == StGap);

  param_cfg_gap_timer #(
    .GapCycles (GAP_CYCLES)
  ) u_gap_timer (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (gap_load),
    .tick_i    (gap_tick),
    .expired_o (gap_expired),
    .bypass_o  (gap_bypass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
`ifdef PARAM_CFG_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StSend;
          idx_q   <= '0;
          valid_q <= 1'b1;
          addr_q  <= '0;
          data_q  <= word_data(4'd0);
          done_q  <= 1'b0;
        end
        StSend: begin
          if (cfg_if.cfg_ready) begin
`ifdef PARAM_CFG_CHECKSUM_EN
            csum_q <= csum_q + data_q;
`endif
            idx_q  <= idx_q + 4'd1;
            if (idx_q == LastIdx) begin
`ifdef PARAM_CFG_CHECKSUM_EN
              state_q <= StCsum;
              addr_q  <= CSUM_ADDR;
              data_q  <= csum_q + data_q;
`else
              state_q <= StDone;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else if (gap_bypass) begin
              addr_q <= idx_q + 4'd1;
              data_q <= word_data(idx_q + 4'd1);
            end else begin
              state_q <= StGap;
              valid_q <= 1'b0;
            end
          end
        end
        StGap: begin
          if (gap_expired) begin
            state_q <= StSend;
            valid_q <= 1'b1;
            addr_q  <= idx_q;
            data_q  <= word_data(idx_q);
          end
        end
`ifdef PARAM_CFG_CHECKSUM_EN
        StCsum: begin
          if (cfg_if.cfg_ready) begin
            state_q <= StDone;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif
        StDone: begin
          if (start) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
`ifdef PARAM_CFG_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg_if.cfg_valid = valid_q;
  assign cfg_if.cfg_addr  = addr_q;
  assign cfg_if.cfg_data  = data_q;
  assign done             = done_q;
  assign busy             = rst_n & ~done_q;
  assign O                = done_q & I;

endmodule

// File: tb/tb_param_cfg_sequencer.sv
// Directed bench: instance A (gap 2, driven ready/start) and instance B (gap 0, ready tied 1).
module tb_param_cfg_sequencer;
  import param_cfg_pkg::*;

`ifdef PARAM_CFG_CHECKSUM_EN
  localparam int NW = 12;
`else
  localparam int NW = 11;
`endif

  logic clk = 1'b0;
  logic rst_n, in_i, start_a;
  logic o_a, o_b, done_a, done_b, busy_a, busy_b;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] exp_data [12] = '{8'h0A, 8'hFF, 8'h41, 8'h20, 8'h73, 8'h74,
                                8'h72, 8'h69, 8'h6E, 8'h67, 8'h2E, 8'h2F};

  param_cfg_sequencer_if cfg_a ();
  param_cfg_sequencer_if cfg_b ();

  always #5 clk = ~clk;

  param_cfg_sequencer #(.GAP_CYCLES(2)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .I      (in_i),
    .O      (o_a),
    .start  (start_a),
    .cfg_if (cfg_a),
    .done   (done_a),
    .busy   (busy_a)
  );

  param_cfg_sequencer #(.GAP_CYCLES(0)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .I      (in_i),
    .O      (o_b),
    .start  (1'b0),
    .cfg_if (cfg_b),
    .done   (done_b),
    .busy   (busy_b)
  );

  assign cfg_b.cfg_ready = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_addr(input int i);
    return (i < 11) ? 4'(i) : 4'hF;
  endfunction

  function automatic int exp_gap(input int i);
    return (i == 0 || i >= 11) ? 0 : 2;
  endfunction

  // Starts with both DUTs about to leave IDLE on the next edge; ready is high throughout.
  task automatic run_seq(input bit with_b);
    int ai, bi, gap, ad, bd;
    ai = 0; bi = 0; gap = 0; ad = 0; bd = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (cfg_a.cfg_valid) begin
        if (ai < NW) begin
          chk("a_addr", 32'(cfg_a.cfg_addr), 32'(exp_addr(ai)));
          chk("a_data", 32'(cfg_a.cfg_data), 32'(exp_data[ai]));
          chk("a_gap", gap, exp_gap(ai));
        end
        ai++;
        gap = 0;
      end else begin
        gap++;
      end
      if (done_a && ad == 0) ad = c;
      if (with_b) begin
        if (cfg_b.cfg_valid) begin
          if (bi < NW) begin
            chk("b_addr", 32'(cfg_b.cfg_addr), 32'(exp_addr(bi)));
            chk("b_data", 32'(cfg_b.cfg_data), 32'(exp_data[bi]));
            chk("b_b2b_cycle", c, bi + 1);
          end
          bi++;
        end
        if (done_b && bd == 0) bd = c;
      end
    end
    chk("a_words", ai, NW);
    chk("a_done_cycle", ad, 1 + NW + 2 * 10);
    if (with_b) begin
      chk("b_words", bi, NW);
      chk("b_done_cycle", bd, 1 + NW);
    end
  endtask

  initial begin
    int   found, n_f;
    logic [7:0] csum_seen;
    rst_n = 1'b0; in_i = 1'b1; start_a = 1'b0; cfg_a.cfg_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(cfg_a.cfg_valid), 0);
    chk("rst_addr", 32'(cfg_a.cfg_addr), 0);
    chk("rst_data", 32'(cfg_a.cfg_data), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_o", 32'(o_a), 0);
    chk("rst_b_valid", 32'(cfg_b.cfg_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_busy", 32'(busy_a), 1);
    chk("rel_done", 32'(done_a), 0);
    run_seq(1'b1);

    // O follows I only in DONE.
    in_i = 1'b0; #1;
    chk("o_track0", 32'(o_a), 0);
    in_i = 1'b1; #1;
    chk("o_track1", 32'(o_a), 1);
    chk("done_busy", 32'(busy_a), 0);

    // Restart via start.
    start_a = 1'b1; step(); start_a = 1'b0;
    chk("start_done", 32'(done_a), 0);
    chk("start_o", 32'(o_a), 0);
    chk("start_busy", 32'(busy_a), 1);
    run_seq(1'b0);

    // Backpressure on addr 3, with a stray start pulse during SEND.
    start_a = 1'b1; step(); start_a = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (cfg_a.cfg_valid && cfg_a.cfg_addr == 4'd3) found = 1;
    end
    chk("find_addr3", found, 1);
    cfg_a.cfg_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      start_a = (k == 2);
      step();
      start_a = 1'b0;
      chk("stall_valid", 32'(cfg_a.cfg_valid), 1);
      chk("stall_addr", 32'(cfg_a.cfg_addr), 3);
      chk("stall_data", 32'(cfg_a.cfg_data), 32'h20);
    end
    cfg_a.cfg_ready = 1'b1;
    step();
    chk("stall_one_xfer", 32'(cfg_a.cfg_valid), 0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step();
      if (cfg_a.cfg_valid) found = 1;
    end
    chk("after_stall_addr", 32'(cfg_a.cfg_addr), 4);
    n_f = 0; csum_seen = 8'h00;
    for (int i = 0; i < 60 && !done_a; i++) begin
      if (cfg_a.cfg_valid && cfg_a.cfg_addr == 4'hF) begin
        n_f++;
        csum_seen = cfg_a.cfg_data;
      end
      step();
    end
    chk("stall_done", 32'(done_a), 1);
`ifdef PARAM_CFG_CHECKSUM_EN
    chk("stall_csum_words", n_f, 1);
    chk("stall_csum", 32'(csum_seen), 32'h2F);
`else
    chk("no_addr_f", n_f, 0);
`endif

    // Reset in the middle of the addr-5 word.
    start_a = 1'b1; step(); start_a = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (cfg_a.cfg_valid && cfg_a.cfg_addr == 4'd5) found = 1;
    end
    chk("find_addr5", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(cfg_a.cfg_valid), 0);
    chk("mid_rst_addr", 32'(cfg_a.cfg_addr), 0);
    chk("mid_rst_data", 32'(cfg_a.cfg_data), 0);
    chk("mid_rst_busy", 32'(busy_a), 0);
    chk("mid_rst_o", 32'(o_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_cfg_sequencer.md
Name: param_cfg_sequencer

Overview:
- Post-reset configuration sequencer for a parameterised pass-through box.
- Serialises the box's integer, sized-integer and string parameters into byte-wide config writes on a valid/ready port, optionally followed by a checksum word.
- Holds the data path (O) low until configuration completes.
- Sits between the box's data path and a downstream config register file; restartable on demand.

Parameters:
- PARAM_INTEGER, 10, untyped integer; low byte sent at addr 0.
- PARAM_INTEGER_SIZED, 65535, declared [7:0]; truncated to 8'hFF at elaboration and sent at addr 1.
- PARAM_STRING, "A string.", string; one byte per character, leftmost character first, addr 2 onward.
- STR_LEN, 9, number of characters in PARAM_STRING; legal range 1..13. Elaboration error outside this range.
- GAP_CYCLES, 2, idle cycles inserted after each accepted word; 0 is legal.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- I  input  1  data input.
- O  output  1  data output: I when done=1, else 0 (combinational).
- start  input  1  single-cycle restart request; honoured only in DONE.
- cfg_valid  output  1  config word valid.
- cfg_ready  input  1  downstream accepts the word.
- cfg_addr  output  4  config word address.
- cfg_data  output  8  config word data.
- done  output  1  configuration complete.
- busy  output  1  sequence in progress.

Behaviour:
- Reset values (async assert): cfg_valid=0, cfg_addr=0, cfg_data=0, done=0, busy=1 after release (0 while rst_n low), O=0. State=IDLE, word index=0, checksum=0, gap counter=0.
- FSM states: IDLE, SEND, GAP, CSUM, DONE.
- IDLE:
  - First cycle after reset release: unconditional -> SEND with index 0.
- SEND:
  - cfg_valid=1; cfg_addr/cfg_data driven from the word table.
  - Word table: index 0 -> PARAM_INTEGER[7:0]; index 1 -> sized value; index k+2 -> character k.
  - cfg_addr/cfg_data stable while cfg_valid=1 and cfg_ready=0.
  - Transfer occurs on the edge where cfg_valid & cfg_ready.
  - On transfer: checksum += cfg_data (mod 256); index++.
  - After the last table word (index 2+STR_LEN-1): -> CSUM, or -> DONE without the optional feature.
  - Otherwise -> GAP if GAP_CYCLES>0, else stay in SEND and present the next word in the next cycle (back-to-back).
- GAP:
  - cfg_valid=0 for exactly GAP_CYCLES cycles, then -> SEND.
- CSUM:
  - cfg_valid=1, cfg_addr=4'hF, cfg_data=checksum.
  - On transfer -> DONE. No gap after the checksum word.
- DONE:
  - done=1, busy=0, cfg_valid=0, O follows I.
  - start=1 -> IDLE: clears done and checksum; O drops to 0 on the next cycle.
- start is ignored in every other state.
- cfg_ready high while cfg_valid=0 has no effect.
- Reset mid-sequence: immediate return to reset values; the sequence restarts from index 0 after release. No partial-word state survives.
- Total words per sequence: 2+STR_LEN, plus 1 if the checksum is enabled. Default = 12.
- Minimum latency, reset release to done with cfg_ready tied 1 and GAP_CYCLES=G: 1 + W + G·(2+STR_LEN−1) cycles, where W is the word count.

Optional Feature:
- Macro: PARAM_CFG_CHECKSUM_EN.
- Defined: CSUM state present; final word at addr 4'hF carries the mod-256 byte sum of all preceding words. Default value is 8'h2F (10+255+806=1071 mod 256).
- Undefined: CSUM state and checksum register removed. DONE is entered directly after the last string byte, and addr 4'hF is never written.

Decomposition:
- Shared package param_cfg_pkg holds:
  - state enum (IDLE, SEND, GAP, CSUM, DONE);
  - CFG_ADDR_W=4, CFG_DATA_W=8;
  - CSUM_ADDR=4'hF, STR_BASE_ADDR=2;
  - a function extracting byte k of a string parameter.
- One natural sub-module: param_cfg_gap_timer, a loadable down-counter for GAP_CYCLES with a zero-length bypass.

Test Plan:
- Defaults, cfg_ready=1, checksum enabled -> 12 transfers.
  - Data in order: 0A, FF, 41, 20, 73, 74, 72, 69, 6E, 67, 2E, 2F.
  - Addrs 0..10 then F.
  - 2 idle cycles between consecutive word transfers, none after the checksum.
  - done=1 after the final transfer.
- cfg_ready held low 5 cycles on word 3 (addr 3) -> cfg_valid, addr 3 and data 0x20 stable all 5 cycles; exactly one transfer logged.
- GAP_CYCLES=0, cfg_ready=1 -> 12 consecutive valid cycles; done at cycle 13 after reset release.
- Assert rst_n low during the addr-5 transfer -> outputs zero immediately; after release the sequence restarts at addr 0 with data 0A; checksum again 2F.
- In DONE, toggle I -> O tracks I. Pulse start -> O=0 and done=0 next cycle, and the full sequence repeats. start pulsed during SEND -> ignored.
- Compile without PARAM_CFG_CHECKSUM_EN -> 11 transfers, no addr F, done after the 0x2E transfer.
